// File: rtl/cgp_output_profiler.sv
// cgp_output_profiler: synchronises the CGP outputs, counts transitions per
// channel over a programmable window, then streams the results over valid/ready.
module cgp_output_profiler #(
  parameter  int N_CH        = 10,
  parameter  int CNT_W       = 16,
  parameter  int WIN_W       = 20,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [N_CH-1:0]  sig_in,
  output logic             busy,
  output logic             done,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_level,
  output logic             rd_last
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_READOUT = 2'd3;

  localparam int FLUSH_LEN = SYNC_STAGES + 1;
  localparam int FL_W      = $clog2(FLUSH_LEN);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_LEN - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(N_CH - 1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  prev_q;
  logic [N_CH-1:0]                  synced;
  logic [N_CH-1:0]                  edge_det;

  logic [1:0]                   state_q;
  logic [FL_W-1:0]              fcnt_q;
  logic [WIN_W-1:0]             win_q;
  logic [WIN_W-1:0]             wcnt_q;
  logic [N_CH-1:0][CNT_W-1:0]   cnt_q;
  logic [N_CH-1:0]              level_q;
  logic [CH_W-1:0]              ch_q;
  logic                         valid_q;
  logic                         done_q;
  logic                         xfer;
  logic                         last_beat;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign edge_det = synced ^ prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= synced;
    end
  end

  assign xfer      = valid_q & rd_ready;
  assign last_beat = (ch_q == CH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      win_q   <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (win_len != '0)) begin
            state_q <= S_FLUSH;
            win_q   <= win_len;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
          end
        end
        S_FLUSH: begin
          if (fcnt_q == FLUSH_LAST) state_q <= S_MEASURE;
          else                      fcnt_q  <= fcnt_q + 1'b1;
        end
        S_MEASURE: begin
          for (int unsigned i = 0; i < N_CH; i++) begin
            if (edge_det[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
          end
          // Final sample also captures levels and presents beat 0 next cycle.
          if (wcnt_q == win_q - 1'b1) begin
            level_q <= synced;
            state_q <= S_READOUT;
            valid_q <= 1'b1;
            ch_q    <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_READOUT: begin
          if (xfer) begin
            if (last_beat) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              ch_q    <= '0;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Beat payload is muxed from the frozen result arrays, so it is stable under backpressure.
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rd_valid = valid_q;
  assign rd_ch    = ch_q;
  assign rd_count = valid_q ? cnt_q[ch_q] : '0;
  assign rd_level = valid_q & level_q[ch_q];
  assign rd_last  = valid_q & last_beat;

endmodule

// File: tb/tb_cgp_output_profiler.sv
// Bench for cgp_output_profiler: randomised sig_in/rd_ready against a
// sample-history reference model; a CNT_W=4 instance shares all inputs.
module tb_cgp_output_profiler;
  localparam int N_CH  = 10;
  localparam int CNT_W = 16;
  localparam int WIN_W = 20;
  localparam int SS    = 2;
  localparam int F     = SS + 1;
  localparam int CH_W  = 4;
  localparam int HMAX  = 20000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             rd_ready = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [N_CH-1:0]  sig_in = '0;

  logic             busy, done, rd_valid, rd_level, rd_last;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_count;
  logic             busy4, done4, rd_valid4, rd_level4, rd_last4;
  logic [CH_W-1:0]  rd_ch4;
  logic [3:0]       rd_count4;

  always #5 clk = ~clk;

  cgp_output_profiler #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .sig_in(sig_in),
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_ch(rd_ch), .rd_count(rd_count), .rd_level(rd_level), .rd_last(rd_last)
  );

  cgp_output_profiler #(.N_CH(N_CH), .CNT_W(4), .WIN_W(WIN_W), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .sig_in(sig_in),
    .busy(busy4), .done(done4), .rd_valid(rd_valid4), .rd_ready(rd_ready),
    .rd_ch(rd_ch4), .rd_count(rd_count4), .rd_level(rd_level4), .rd_last(rd_last4)
  );

  // hist[n] is the sig_in value sampled by rising edge number n.
  int unsigned     ecount = 0;
  logic [N_CH-1:0] hist [HMAX];
  always @(posedge clk) begin
    if (ecount < HMAX) hist[ecount] = sig_in;
    ecount++;
  end

  int checks = 0;
  int failures = 0;
  int unsigned     exp_cnt [N_CH];
  logic [N_CH-1:0] exp_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_valid"}, rd_valid, 0);
    check({pfx, "_ch"}, rd_ch, 0);
    check({pfx, "_count"}, rd_count, 0);
    check({pfx, "_level"}, rd_level, 0);
    check({pfx, "_last"}, rd_last, 0);
    check({pfx, "_valid4"}, rd_valid4, 0);
    check({pfx, "_count4"}, rd_count4, 0);
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Window samples are the synchroniser outputs seen at edges E0+F+1..E0+F+W,
  // each of which is the raw sample taken SS edges earlier.
  task automatic model(input int unsigned e0, input int unsigned w);
    logic [N_CH-1:0] d;
    for (int i = 0; i < N_CH; i++) exp_cnt[i] = 0;
    for (int unsigned t = e0 + F + 1; t <= e0 + F + w; t++) begin
      d = hist[t-SS] ^ hist[t-SS-1];
      for (int i = 0; i < N_CH; i++) if (d[i]) exp_cnt[i]++;
    end
    exp_lvl = hist[e0 + F + w - SS];
  endtask

  function automatic logic [N_CH-1:0] next_sig(input int mode, input int unsigned k,
                                              input logic [N_CH-1:0] cur);
    logic [N_CH-1:0] v;
    logic [N_CH-1:0] m;
    v = cur;
    m = '0;
    case (mode)
      1: begin
        v = cur & 10'b00_0000_1001;
        v[0] = ~v[0];
        if (k % 4 == 0) v[3] = ~v[3];
      end
      2: begin
        v = cur & 10'b10_0000_0000;
        v[9] = ~v[9];
      end
      3: v = N_CH'($urandom);
      4: begin
        m[$urandom_range(0, N_CH-1)] = 1'b1;
        if ($urandom_range(0, 2) == 0) v = cur ^ m;
      end
      default: v = cur;
    endcase
    return v;
  endfunction

  task automatic run(input int unsigned w, input int smode, input int rmode, input bit poke);
    int unsigned e0, guard, beat, nval;
    bit seen;
    bit pat [6];
    pat = '{1, 0, 0, 1, 0, 1};
    start = 1'b1;
    win_len = WIN_W'(w);
    rd_ready = 1'b0;
    e0 = ecount;
    seen = 0;
    guard = 0;
    while (!seen && guard < w + 50) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (ecount == e0 + 1) begin
        check("done_cleared", done, 0);
        check("busy_after_start", busy, 1);
      end
      if (rd_valid) begin
        seen = 1;
        check("valid_latency", ecount - 1 - e0, F + w);
      end else begin
        if (busy) check("valid_low_measure", rd_valid, 0);
        sig_in = next_sig(smode, ecount, sig_in);
        if (poke && ecount == e0 + F + 1 + w / 2) begin
          start = 1'b1;
          win_len = 7;
        end
      end
    end
    if (!seen) begin
      check("valid_timeout", 0, 1);
      return;
    end
    model(e0, w);
    beat = 0;
    nval = 0;
    guard = 0;
    while (beat < N_CH && guard < 400) begin
      check("rd_valid", rd_valid, 1);
      check("rd_busy", busy, 1);
      check("rd_done", done, 0);
      check("rd_ch", rd_ch, beat);
      check($sformatf("count_ch%0d", beat), rd_count, sat(exp_cnt[beat], CNT_W));
      check($sformatf("level_ch%0d", beat), rd_level, exp_lvl[beat]);
      check($sformatf("last_ch%0d", beat), rd_last, (beat == N_CH - 1));
      check("rd_ch4", rd_ch4, beat);
      check($sformatf("count4_ch%0d", beat), rd_count4, sat(exp_cnt[beat], 4));
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = pat[nval % 6];
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      nval++;
      if (rd_ready) beat++;
      if (smode != 0) sig_in = next_sig(smode, ecount, sig_in);
      @(negedge clk);
      guard++;
    end
    if (beat < N_CH) check("readout_timeout", beat, N_CH);
    if (rmode == 0) check("readout_cycles", nval, N_CH);
    check("done_pulse", done, 1);
    check("done_pulse4", done4, 1);
    check("valid_after_last", rd_valid, 0);
    check("busy_after_last", busy, 0);
    rd_ready = 1'b0;
  endtask

  initial begin : main
    int unsigned e0, guard;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // win_len == 0 must be ignored
    start = 1'b1;
    win_len = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("zero_win_busy", busy, 0);
      check("zero_win_valid", rd_valid, 0);
      @(negedge clk);
    end

    sig_in = '1;
    repeat (3) @(negedge clk);
    run(100, 0, 0, 0);
    sig_in = '0;
    run(64, 1, 0, 0);
    sig_in = '0;
    run(40, 2, 0, 0);
    run(30, 3, 1, 0);
    run(60, 4, 2, 1);
    run(1, 3, 0, 0);
    for (int k = 0; k < 6; k++)
      run($urandom_range(1, 80), int'($urandom_range(3, 4)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    // reset at MEASURE cycle 20 of 50
    @(negedge clk);
    start = 1'b1;
    win_len = 50;
    e0 = ecount;
    guard = 0;
    while (ecount != e0 + F + 1 + 20 && guard < 100) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      sig_in = next_sig(3, ecount, sig_in);
    end
    check("mid_measure_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_measure");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(50, 3, 0, 0);

    // reset while a beat is stalled
    @(negedge clk);
    start = 1'b1;
    win_len = 12;
    rd_ready = 1'b0;
    guard = 0;
    while (!rd_valid && guard < 60) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      sig_in = next_sig(3, ecount, sig_in);
    end
    @(negedge clk);
    check("stalled_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_readout");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(5, 4, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cgp_output_profiler.md
Name: cgp_output_profiler

Overview:
Downstream capture stage for the evolved CGP circuit. It samples the 10 CGP outputs, which may be asynchronous or oscillating, through synchronisers. Over a programmable window it counts transitions on each output, then streams per-channel results out over a valid/ready interface. This gives a clocked, measurable fitness readout of an otherwise purely combinational evolved netlist.

Parameters:
N_CH, 10, number of monitored CGP outputs
CNT_W, 16, width of each per-channel transition counter (saturating)
WIN_W, 20, width of the window-length input
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
CH_W, $clog2(N_CH), derived channel-index width, not overridden (4 at default)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a measurement; sampled only in IDLE
win_len  in  WIN_W  measurement window in clk cycles; latched when start is accepted
sig_in  in  N_CH  raw CGP outputs (out0 = bit 0 ... out9 = bit 9), asynchronous to clk
busy  out  1  high in FLUSH, MEASURE and READOUT
done  out  1  one-cycle pulse after the final readout handshake
rd_valid  out  1  result beat valid
rd_ready  in  1  consumer accepts beat
rd_ch  out  CH_W  channel index of the current beat
rd_count  out  CNT_W  transition count for rd_ch
rd_level  out  1  synchronised level of rd_ch at end of window
rd_last  out  1  high on the beat for channel N_CH-1

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters, latched levels and the window counter at 0; busy=0, done=0, rd_valid=0, rd_ch=0, rd_count=0, rd_level=0, rd_last=0. Reset mid-operation aborts immediately and rd_valid drops the same instant. No partial results survive reset.
- Sync path: each sig_in bit passes through SYNC_STAGES flops, then one "prev" flop. edge[i] = sync[i] XOR prev[i]. Both rising and falling transitions count.
- IDLE: start=1 with win_len!=0 is accepted on edge E0. The block latches win_len, clears all counters and enters FLUSH. start with win_len==0 is ignored and the block stays in IDLE. start outside IDLE is ignored.
- FLUSH: lasts F = SYNC_STAGES+1 cycles with no counting, so stale synchroniser contents are discarded. At E0+F the block enters MEASURE.
- MEASURE: counters update on edges E0+F+1 through E0+F+win_len, exactly win_len samples. count[i] increments by 1 when edge[i]=1 and saturates at 2^CNT_W-1 with no wrap. At the last sample edge, level[i] latches sync[i], the state becomes READOUT and rd_valid is registered high. At defaults, rd_valid first rises 3+win_len edges after E0.
- READOUT: beats run for channels 0..N_CH-1 in order, with rd_ch = index, rd_count = count[index], rd_level = level[index], rd_last = (index==N_CH-1).
- A transfer occurs when rd_valid & rd_ready on a clock edge. While rd_valid & !rd_ready, all rd_* outputs hold stable. The next beat is presented on the cycle after a transfer. There are no bubbles when rd_ready is held high, so the full readout takes N_CH cycles.
- When the last beat transfers, the next edge sets the state to IDLE, rd_valid=0 and done=1 for exactly one cycle. A start arriving in that same cycle is accepted, since the state is IDLE.
- sig_in activity outside MEASURE never affects counts.

Test Plan:
- Static inputs: all sig_in=1 (the CGP bench tie-high case), win_len=100 -> 10 beats, every rd_count=0, rd_level=1, rd_last only on rd_ch=9, then done pulse. rd_valid first high exactly 103 edges after start.
- Toggle: sig_in[0] inverted every clk, sig_in[3] inverted every 4th clk, others 0, win_len=64 -> ch0 count=64, ch3 count=16, all others 0.
- Saturation: override CNT_W=4, toggle sig_in[9] every clk, win_len=40 -> ch9 count=15, rd_last=1 on that beat.
- Backpressure: rd_ready pattern 1,0,0,1,0,1... -> rd_ch/rd_count/rd_level stable during stalls, each channel delivered exactly once in order 0..9. With rd_ready held high throughout, the readout completes in 10 cycles.
- Illegal and ignored starts: start with win_len=0 -> stays IDLE, busy=0. start pulsed during MEASURE -> no restart, counts unaffected.
- Reset mid-measure: deassert rst_n in MEASURE cycle 20 of 50 -> outputs 0 immediately. After release and a new start with win_len=50, counts reflect only the new window.
